// File: rtl/gemm_pkg.sv
// Shared types and default parameters for the GEMM tile scheduler.
package gemm_pkg;

    localparam int IDX_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FIRE = 3'd2,
        ST_WAIT = 3'd3,
        ST_WB   = 3'd4,
        ST_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/sched_timeout_cnt.sv
// WAIT-state watchdog: cleared by load, counts while enabled, flags the final allowed cycle.
module sched_timeout_cnt
    import gemm_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Cycle counter; holds at terminal count so tc stays asserted until reloaded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && !tc) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == TC_VAL);

endmodule

// File: rtl/gemm_tile_sched.sv
// Walks a K x N tile grid: fetch operands, launch the array, wait, write back each N tile.
module gemm_tile_sched
    import gemm_pkg::*;
#(
    parameter int IDX_W   = IDX_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] cfg_k_tiles,
    input  logic [IDX_W-1:0] cfg_n_tiles,
    input  logic             cfg_bias_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ld_valid,
    input  logic             ld_ready,
    output logic [IDX_W-1:0] ld_k_idx,
    output logic [IDX_W-1:0] ld_n_idx,
    output logic             arr_gen_done,
    output logic             arr_acc_clr,
    output logic             arr_bias_en,
    input  logic             arr_done,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [IDX_W-1:0] wb_n_idx
);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    state_e state_r;
    state_e next_state_s;

    logic [IDX_W-1:0] k_r, n_r, cfg_k_r, cfg_n_r;
    logic [IDX_W-1:0] k_next_s, n_next_s, cfg_k_next_s, cfg_n_next_s;
    logic             bias_r, bias_next_s;

    logic accept_s, last_k_s, last_n_s, ld_hs_s, wb_hs_s;
    logic tmo_load_s, tmo_en_s, tmo_tc_s;

    logic             busy_next_s, done_next_s, err_next_s, ld_valid_next_s;
    logic             gen_next_s, acc_clr_next_s, bias_en_next_s, wb_valid_next_s;

    // Counters stop at cfg-1, so "last" is an equality against the latched count minus one
    function automatic logic is_last(input logic [IDX_W-1:0] idx, input logic [IDX_W-1:0] cfg);
        return (idx == (cfg - IDX_W'(1)));
    endfunction

    assign accept_s = start && (cfg_k_tiles != IDX_ZERO) && (cfg_n_tiles != IDX_ZERO);
    assign last_k_s = is_last(k_r, cfg_k_r);
    assign last_n_s = is_last(n_r, cfg_n_r);
    assign ld_hs_s  = ld_valid && ld_ready;
    assign wb_hs_s  = wb_valid && wb_ready;

    assign tmo_load_s = (state_r == ST_FIRE);
    assign tmo_en_s   = (state_r == ST_WAIT);

    sched_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .load(tmo_load_s),
        .en  (tmo_en_s),
        .tc  (tmo_tc_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; arr_done takes priority over the watchdog terminal count
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (ld_hs_s) begin
                    next_state_s = ST_FIRE;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_FIRE: begin
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (arr_done) begin
                    next_state_s = last_k_s ? ST_WB : ST_LOAD;
                end else if (tmo_tc_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_WB: begin
                if (wb_hs_s) begin
                    next_state_s = last_n_s ? ST_DONE : ST_LOAD;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Tile index, latched config and error-pulse next values
    always_comb begin
        k_next_s     = k_r;
        n_next_s     = n_r;
        cfg_k_next_s = cfg_k_r;
        cfg_n_next_s = cfg_n_r;
        bias_next_s  = bias_r;
        err_next_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cfg_k_next_s = cfg_k_tiles;
                    cfg_n_next_s = cfg_n_tiles;
                    bias_next_s  = cfg_bias_en;
                    k_next_s     = IDX_ZERO;
                    n_next_s     = IDX_ZERO;
                end else if (start) begin
                    err_next_s = 1'b1;
                end else begin
                    err_next_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (arr_done) begin
                    if (!last_k_s) begin
                        k_next_s = k_r + IDX_W'(1);
                    end else begin
                        k_next_s = k_r;
                    end
                end else if (tmo_tc_s) begin
                    err_next_s = 1'b1;
                    k_next_s   = IDX_ZERO;
                    n_next_s   = IDX_ZERO;
                end else begin
                    k_next_s = k_r;
                end
            end
            ST_WB: begin
                if (wb_hs_s) begin
                    k_next_s = IDX_ZERO;
                    if (last_n_s) begin
                        n_next_s = IDX_ZERO;
                    end else begin
                        n_next_s = n_r + IDX_W'(1);
                    end
                end else begin
                    n_next_s = n_r;
                end
            end
            default: begin
                err_next_s = 1'b0;
            end
        endcase
    end

    // Index and latched-config registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_r     <= IDX_ZERO;
            n_r     <= IDX_ZERO;
            cfg_k_r <= IDX_ZERO;
            cfg_n_r <= IDX_ZERO;
            bias_r  <= 1'b0;
        end else begin
            k_r     <= k_next_s;
            n_r     <= n_next_s;
            cfg_k_r <= cfg_k_next_s;
            cfg_n_r <= cfg_n_next_s;
            bias_r  <= bias_next_s;
        end
    end

    // Output decode from the upcoming state so every output can be a flop
    always_comb begin
        busy_next_s     = (next_state_s != ST_IDLE);
        done_next_s     = (next_state_s == ST_DONE);
        ld_valid_next_s = (next_state_s == ST_LOAD);
        gen_next_s      = (next_state_s == ST_FIRE);
        acc_clr_next_s  = (next_state_s == ST_FIRE) && (k_next_s == IDX_ZERO);
        bias_en_next_s  = (next_state_s == ST_FIRE) && bias_next_s
                          && is_last(k_next_s, cfg_k_next_s);
        wb_valid_next_s = (next_state_s == ST_WB);
    end

    // Registered outputs; no combinational path from ready inputs to valids
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            ld_valid     <= 1'b0;
            arr_gen_done <= 1'b0;
            arr_acc_clr  <= 1'b0;
            arr_bias_en  <= 1'b0;
            wb_valid     <= 1'b0;
            ld_k_idx     <= IDX_ZERO;
            ld_n_idx     <= IDX_ZERO;
            wb_n_idx     <= IDX_ZERO;
        end else begin
            busy         <= busy_next_s;
            done         <= done_next_s;
            err          <= err_next_s;
            ld_valid     <= ld_valid_next_s;
            arr_gen_done <= gen_next_s;
            arr_acc_clr  <= acc_clr_next_s;
            arr_bias_en  <= bias_en_next_s;
            wb_valid     <= wb_valid_next_s;
            ld_k_idx     <= k_next_s;
            ld_n_idx     <= n_next_s;
            wb_n_idx     <= n_next_s;
        end
    end

endmodule

// File: tb/tb_gemm_tile_sched.sv
// Self-checking bench for gemm_tile_sched against a tile-grid reference model.
module tb_gemm_tile_sched;

    logic       clk, rst, start, cfg_bias_en, ld_ready, arr_done, wb_ready;
    logic [7:0] cfg_k_tiles, cfg_n_tiles;
    logic       busy, done, err, ld_valid, arr_gen_done, arr_acc_clr, arr_bias_en, wb_valid;
    logic [7:0] ld_k_idx, ld_n_idx, wb_n_idx;

    int n_checks, n_fail;

    // observed events and reference expectations
    logic [7:0] fk_q[$], fn_q[$], wb_q[$], ek_q[$], en_q[$], ewb_q[$];
    bit         fclr_q[$], fbias_q[$], eclr_q[$], ebias_q[$];
    int         done_cnt, err_cnt, viol_cnt, ld_first_hi, bias_seen;
    bit         budget_out;
    logic       post_busy, post_done;

    gemm_tile_sched #(.IDX_W(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_k_tiles(cfg_k_tiles), .cfg_n_tiles(cfg_n_tiles), .cfg_bias_en(cfg_bias_en),
        .busy(busy), .done(done), .err(err),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_k_idx(ld_k_idx), .ld_n_idx(ld_n_idx),
        .arr_gen_done(arr_gen_done), .arr_acc_clr(arr_acc_clr), .arr_bias_en(arr_bias_en),
        .arr_done(arr_done), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_n_idx(wb_n_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: row-major walk over N, inner K; clear on k=0, bias on last k
    function automatic void build_model(input int kt, input int nt, input bit bias);
        ek_q.delete(); en_q.delete(); eclr_q.delete(); ebias_q.delete(); ewb_q.delete();
        for (int n = 0; n < nt; n++) begin
            for (int k = 0; k < kt; k++) begin
                ek_q.push_back(8'(k));
                en_q.push_back(8'(n));
                eclr_q.push_back(k == 0);
                ebias_q.push_back(bias && (k == kt - 1));
            end
            ewb_q.push_back(8'(n));
        end
    endfunction

    // Environment driver: answers handshakes and records what the DUT does
    task automatic run_job(input int kt, input int nt, input bit bias, input int ld_stall,
                           input int wb_stall, input int lat, input bit rnd_stall,
                           input bit noise, input bit toggle);
        int cyc, ld_wait, wb_wait, arr_cnt;
        bit fire_due, in_ld, in_wb, finished;
        logic [7:0] hk, hn, hw;
        fk_q.delete(); fn_q.delete(); wb_q.delete(); fclr_q.delete(); fbias_q.delete();
        done_cnt = 0; err_cnt = 0; viol_cnt = 0; ld_first_hi = 0; bias_seen = 0; budget_out = 0;
        ld_wait = 0; wb_wait = 0; hk = 8'd0; hn = 8'd0; hw = 8'd0;
        @(negedge clk);
        start = 1'b1; cfg_k_tiles = 8'(kt); cfg_n_tiles = 8'(nt); cfg_bias_en = bias;
        @(negedge clk);
        start = 1'b0;
        if (ld_valid !== 1'b1 || busy !== 1'b1) viol_cnt++;
        arr_cnt = -1; fire_due = 0; in_ld = 0; in_wb = 0; finished = 0; cyc = 0;
        while (!finished && cyc < 20000) begin
            if (arr_gen_done !== fire_due) viol_cnt++;
            fire_due = 0;
            if (arr_gen_done === 1'b1) begin
                fclr_q.push_back(arr_acc_clr);
                fbias_q.push_back(arr_bias_en);
                arr_cnt = (lat > 0) ? lat : -1;
            end
            if (arr_bias_en === 1'b1) bias_seen++;
            if (done === 1'b1) done_cnt++;
            if (err === 1'b1) err_cnt++;
            if (done === 1'b1 || err === 1'b1) finished = 1;
            ld_ready = 1'b0; wb_ready = 1'b0; arr_done = 1'b0;
            if (!finished) begin
                if (ld_valid === 1'b1) begin
                    if (!in_ld) begin
                        in_ld = 1; hk = ld_k_idx; hn = ld_n_idx;
                        ld_wait = rnd_stall ? int'($urandom_range(ld_stall, 0)) : ld_stall;
                    end else if (ld_k_idx !== hk || ld_n_idx !== hn) begin
                        viol_cnt++;
                    end
                    if (fk_q.size() == 0) ld_first_hi++;
                    if (ld_wait == 0) begin
                        ld_ready = 1'b1; fk_q.push_back(hk); fn_q.push_back(hn);
                        in_ld = 0; fire_due = 1;
                    end else begin
                        ld_wait--;
                    end
                    if (noise) arr_done = 1'b1;
                end else if (in_ld) begin
                    viol_cnt++; in_ld = 0;
                end
                if (arr_cnt == 0) begin
                    arr_done = 1'b1; arr_cnt = -1;
                end else if (arr_cnt > 0) begin
                    arr_cnt--;
                end
                if (wb_valid === 1'b1) begin
                    if (!in_wb) begin
                        in_wb = 1; hw = wb_n_idx;
                        wb_wait = rnd_stall ? int'($urandom_range(wb_stall, 0)) : wb_stall;
                    end else if (wb_n_idx !== hw) begin
                        viol_cnt++;
                    end
                    if (wb_wait == 0) begin
                        wb_ready = 1'b1; wb_q.push_back(hw); in_wb = 0;
                    end else begin
                        wb_wait--;
                    end
                end else if (in_wb) begin
                    viol_cnt++; in_wb = 0;
                end
                if (toggle) begin
                    start = 1'($urandom_range(1, 0));
                    cfg_k_tiles = 8'($urandom); cfg_n_tiles = 8'($urandom);
                    cfg_bias_en = 1'($urandom_range(1, 0));
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!finished) budget_out = 1;
        @(negedge clk);
        post_busy = busy; post_done = done;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, err, ld_valid, arr_gen_done, arr_acc_clr, arr_bias_en, wb_valid,
             ld_k_idx, ld_n_idx, wb_n_idx} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b ld_valid=%b wb_valid=%b idx=%h/%h/%h, expected all 0",
                     busy, ld_valid, wb_valid, ld_k_idx, ld_n_idx, wb_n_idx);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, err, ld_valid, arr_gen_done, wb_valid} !== 6'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b err=%b, expected 0", busy, done, err);
        end
    endtask

    task automatic test_basic;
        build_model(2, 3, 1'b1);
        run_job(2, 3, 1'b1, 0, 0, 4, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (fk_q.size() != ek_q.size() || fclr_q.size() != ek_q.size()) begin
            n_fail++;
            $display("FAIL basic_fetch_count: got %0d fetches %0d fires, expected %0d",
                     fk_q.size(), fclr_q.size(), ek_q.size());
        end else begin
            for (int i = 0; i < ek_q.size(); i++) begin
                n_checks++;
                if ({fk_q[i], fn_q[i], fclr_q[i], fbias_q[i]} !== {ek_q[i], en_q[i], eclr_q[i], ebias_q[i]}) begin
                    n_fail++;
                    $display("FAIL basic_fetch[%0d]: got k=%0d n=%0d clr=%b bias=%b, expected k=%0d n=%0d clr=%b bias=%b",
                             i, fk_q[i], fn_q[i], fclr_q[i], fbias_q[i], ek_q[i], en_q[i], eclr_q[i], ebias_q[i]);
                end
            end
        end
        n_checks++;
        if (wb_q.size() != 3 || wb_q[0] !== 8'd0 || wb_q[1] !== 8'd1 || wb_q[2] !== 8'd2) begin
            n_fail++;
            $display("FAIL basic_wb: got %0d writebacks, expected n=0,1,2", wb_q.size());
        end
        n_checks++;
        if (done_cnt != 1 || err_cnt != 0 || viol_cnt != 0 || budget_out || post_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: got done=%0d err=%0d viol=%0d timeout=%b busy=%b, expected 1/0/0/0/0",
                     done_cnt, err_cnt, viol_cnt, budget_out, post_busy);
        end
    endtask

    task automatic test_ld_stall;
        run_job(1, 1, 1'b0, 5, 0, 3, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (ld_first_hi != 6 || viol_cnt != 0) begin
            n_fail++;
            $display("FAIL ld_stall_hold: got %0d valid cycles viol=%0d, expected 6 and 0", ld_first_hi, viol_cnt);
        end
        n_checks++;
        if (bias_seen != 0 || done_cnt != 1 || err_cnt != 0 || wb_q.size() != 1 || fk_q.size() != 1) begin
            n_fail++;
            $display("FAIL ld_stall_job: got bias=%0d done=%0d err=%0d wb=%0d fetch=%0d, expected 0/1/0/1/1",
                     bias_seen, done_cnt, err_cnt, wb_q.size(), fk_q.size());
        end
    endtask

    task automatic test_zero_cfg;
        logic [7:0] kv[3];
        logic [7:0] nv[3];
        kv[0] = 8'd0; nv[0] = 8'd3;
        kv[1] = 8'd5; nv[1] = 8'd0;
        kv[2] = 8'd0; nv[2] = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; cfg_k_tiles = kv[i]; cfg_n_tiles = nv[i]; cfg_bias_en = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if ({err, busy, ld_valid} !== 3'b100) begin
                n_fail++;
                $display("FAIL zero_cfg_err[%0d]: got err=%b busy=%b ld_valid=%b, expected 1/0/0", i, err, busy, ld_valid);
            end
            @(negedge clk);
            n_checks++;
            if ({err, busy, ld_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL zero_cfg_pulse[%0d]: got err=%b busy=%b ld_valid=%b, expected 0/0/0", i, err, busy, ld_valid);
            end
        end
    endtask

    task automatic test_timeout;
        int bad;
        @(negedge clk);
        start = 1'b1; cfg_k_tiles = 8'd1; cfg_n_tiles = 8'd1; cfg_bias_en = 1'b0;
        @(negedge clk);
        start = 1'b0; ld_ready = 1'b1;
        for (int i = 0; i < 10 && arr_gen_done !== 1'b1; i++) @(negedge clk);
        ld_ready = 1'b0;
        n_checks++;
        if (arr_gen_done !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_fire: got arr_gen_done=%b, expected 1", arr_gen_done);
        end
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || err !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL timeout_wait: got %0d early-exit cycles, expected 0", bad);
        end
        @(negedge clk);
        n_checks++;
        if ({err, busy, ld_valid, wb_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%b busy=%b ld_valid=%b wb_valid=%b, expected 1/0/0/0",
                     err, busy, ld_valid, wb_valid);
        end
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got err=%b, expected 0", err);
        end
        // arr_done on the final allowed cycle still completes the job
        run_job(1, 1, 1'b0, 0, 0, 16, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (done_cnt != 1 || err_cnt != 0 || viol_cnt != 0) begin
            n_fail++;
            $display("FAIL timeout_edge_win: got done=%0d err=%0d viol=%0d, expected 1/0/0", done_cnt, err_cnt, viol_cnt);
        end
        run_job(1, 1, 1'b0, 0, 0, 17, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (done_cnt != 0 || err_cnt != 1 || post_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_late: got done=%0d err=%0d busy=%b, expected 0/1/0", done_cnt, err_cnt, post_busy);
        end
    endtask

    task automatic test_wb_stall_start_toggle;
        build_model(2, 2, 1'b0);
        run_job(2, 2, 1'b0, 1, 3, 2, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (wb_q.size() != 2 || wb_q[0] !== 8'd0 || wb_q[1] !== 8'd1 || viol_cnt != 0) begin
            n_fail++;
            $display("FAIL wb_stall_hold: got %0d writebacks viol=%0d, expected 2 in order and 0", wb_q.size(), viol_cnt);
        end
        n_checks++;
        if (done_cnt != 1 || err_cnt != 0 || fk_q.size() != ek_q.size() || bias_seen != 0 || post_done !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_stall_job: got done=%0d err=%0d fetch=%0d bias=%0d, expected 1/0/%0d/0",
                     done_cnt, err_cnt, fk_q.size(), bias_seen, ek_q.size());
        end
    endtask

    task automatic test_random_jobs;
        int kt, nt;
        bit bias;
        for (int j = 0; j < 8; j++) begin
            kt   = (j == 0) ? 255 : (j == 1) ? 1 : int'($urandom_range(5, 1));
            nt   = (j == 0) ? 2 : (j == 1) ? 255 : int'($urandom_range(5, 1));
            bias = 1'($urandom_range(1, 0));
            build_model(kt, nt, bias);
            run_job(kt, nt, bias, (j < 2) ? 0 : 3, (j < 2) ? 0 : 3, int'($urandom_range(16, 1)),
                    1'b1, 1'($urandom_range(1, 0)), 1'b0);
            n_checks++;
            if (fk_q.size() != ek_q.size() || fclr_q.size() != ek_q.size() || wb_q.size() != ewb_q.size()) begin
                n_fail++;
                $display("FAIL rand%0d_counts: got %0d fetch %0d fire %0d wb, expected %0d/%0d/%0d",
                         j, fk_q.size(), fclr_q.size(), wb_q.size(), ek_q.size(), ek_q.size(), ewb_q.size());
            end else begin
                for (int i = 0; i < ek_q.size(); i++) begin
                    n_checks++;
                    if ({fk_q[i], fn_q[i], fclr_q[i], fbias_q[i]} !== {ek_q[i], en_q[i], eclr_q[i], ebias_q[i]}) begin
                        n_fail++;
                        $display("FAIL rand%0d_fetch[%0d]: got k=%0d n=%0d clr=%b bias=%b, expected k=%0d n=%0d clr=%b bias=%b",
                                 j, i, fk_q[i], fn_q[i], fclr_q[i], fbias_q[i], ek_q[i], en_q[i], eclr_q[i], ebias_q[i]);
                    end
                end
                for (int i = 0; i < ewb_q.size(); i++) begin
                    n_checks++;
                    if (wb_q[i] !== ewb_q[i]) begin
                        n_fail++;
                        $display("FAIL rand%0d_wb[%0d]: got n=%0d, expected n=%0d", j, i, wb_q[i], ewb_q[i]);
                    end
                end
            end
            n_checks++;
            if (done_cnt != 1 || err_cnt != 0 || viol_cnt != 0 || budget_out || post_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_end: got done=%0d err=%0d viol=%0d timeout=%b busy=%b, expected 1/0/0/0/0",
                         j, done_cnt, err_cnt, viol_cnt, budget_out, post_busy);
            end
        end
    endtask

    task automatic test_reset_mid_job;
        int seen;
        @(negedge clk);
        start = 1'b1; cfg_k_tiles = 8'd2; cfg_n_tiles = 8'd2; cfg_bias_en = 1'b1;
        @(negedge clk);
        start = 1'b0; ld_ready = 1'b1; arr_done = 1'b1; wb_ready = 1'b0;
        for (int i = 0; i < 60 && wb_valid !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (wb_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_reach_wb: got wb_valid=%b, expected 1", wb_valid);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, err, ld_valid, arr_gen_done, arr_acc_clr, arr_bias_en, wb_valid,
             ld_k_idx, ld_n_idx, wb_n_idx} !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got busy=%b wb_valid=%b wb_n_idx=%0d, expected all 0", busy, wb_valid, wb_n_idx);
        end
        ld_ready = 1'b0; arr_done = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1 || err === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: got %0d cycles with done/err/busy, expected 0", seen);
        end
        run_job(2, 2, 1'b1, 0, 0, 2, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (fk_q.size() != 4 || fk_q[0] !== 8'd0 || fn_q[0] !== 8'd0 || done_cnt != 1 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL rst_mid_fresh: got %0d fetches first=(%0d,%0d) done=%0d err=%0d, expected 4 (0,0) 1 0",
                     fk_q.size(), (fk_q.size() > 0) ? fk_q[0] : 8'hff, (fn_q.size() > 0) ? fn_q[0] : 8'hff,
                     done_cnt, err_cnt);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b0; start = 1'b0; cfg_k_tiles = 8'd0; cfg_n_tiles = 8'd0; cfg_bias_en = 1'b0;
        ld_ready = 1'b0; arr_done = 1'b0; wb_ready = 1'b0;
        test_reset;
        test_basic;
        test_ld_stall;
        test_zero_cfg;
        test_timeout;
        test_wb_stall_start_toggle;
        test_random_jobs;
        test_reset_mid_job;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gemm_tile_sched.md
GEMM_TILE_SCHED -- requirements
Module: gemm_tile_sched

Interface
REQ-001 Parameter IDX_W, default 8: width of tile counters and config fields.
REQ-002 Parameter TIMEOUT, default 1024: max cycles WAIT may last before arr_done.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  job request; sampled only in IDLE.
REQ-006 cfg_k_tiles  input  IDX_W  number of K tiles per output tile; latched at accepted start.
REQ-007 cfg_n_tiles  input  IDX_W  number of N output tiles; latched at accepted start.
REQ-008 cfg_bias_en  input  1  add bias on final K tile; latched at accepted start.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse at job completion.
REQ-011 err  output  1  one-cycle pulse on zero config or timeout.
REQ-012 ld_valid / ld_ready  output / input  1 / 1  operand-tile fetch handshake.
REQ-013 ld_k_idx, ld_n_idx  output  IDX_W each  tile indices of the current fetch.
REQ-014 arr_gen_done  output  1  one-cycle pulse launching the GEMM array on the loaded A/B/bias.
REQ-015 arr_acc_clr  output  1  qualifies arr_gen_done; high when k index is 0.
REQ-016 arr_bias_en  output  1  qualifies arr_gen_done; high on last K tile when cfg_bias_en is latched as 1.
REQ-017 arr_done  input  1  array completion pulse; honoured only in WAIT.
REQ-018 wb_valid / wb_ready  output / input  1 / 1  result writeback handshake.
REQ-019 wb_n_idx  output  IDX_W  N index of the written-back result.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, FIRE, WAIT, WB, DONE.
REQ-021 IDLE: start=1 with both cfg fields nonzero -> latch cfg, k=0, n=0, go LOAD; start=1 with either field 0 -> err pulse next cycle, stay IDLE.
REQ-022 LOAD: ld_valid=1, indices = current k, n, all held stable until ld_valid&&ld_ready; on handshake -> FIRE.
REQ-023 FIRE: exactly one cycle; arr_gen_done=1 with arr_acc_clr/arr_bias_en per REQ-015/016; -> WAIT.
REQ-024 WAIT: arr_done=1 -> last k: go WB; else k+1, go LOAD. Cycle counter reset on entry; reaching TIMEOUT without arr_done -> err pulse, go IDLE.
REQ-025 WB: wb_valid=1, wb_n_idx=n held until wb_valid&&wb_ready; then last n -> DONE, else n+1, k=0, go LOAD.
REQ-026 DONE: done=1 for one cycle; -> IDLE.
REQ-027 Latency: accepted start -> ld_valid high on the next cycle; ld handshake -> arr_gen_done next cycle.
REQ-028 start outside IDLE SHALL be ignored; cfg changes after acceptance SHALL have no effect.
REQ-029 arr_done outside WAIT and arr_done coinciding with timeout terminal count: arr_done wins, no err.
REQ-030 Counters compare against latched cfg minus 1; no wrap past cfg_*_tiles-1; cfg value 2^IDX_W-1 SHALL work.
REQ-031 All handshake outputs SHALL be registered; no combinational path from ready inputs to valid outputs.

Reset
REQ-032 On rst low: state=IDLE, k=n=0, latched cfg=0, timeout counter=0, and busy, done, err, ld_valid, arr_gen_done, arr_acc_clr, arr_bias_en, wb_valid all 0, index outputs 0.
REQ-033 Reset asserted mid-job SHALL abort immediately with no done or err pulse after release.

Structure
REQ-034 Shared package gemm_pkg SHALL hold the state enum type and IDX_W/TIMEOUT defaults.
REQ-035 One sub-module, sched_timeout_cnt (load/enable/terminal-count), SHALL implement the WAIT watchdog; FSM and index counters stay in gemm_tile_sched.

Verification
REQ-036 k=2, n=3, bias=1, ready tied 1, arr_done 4 cycles after each arr_gen_done -> 6 fetches, indices (0,0),(1,0),(0,1)...(1,2); arr_acc_clr on k=0, arr_bias_en on k=1 only; 3 wb, one done.
REQ-037 k=1, n=1, bias=0, ld_ready held low 5 cycles -> ld_valid/indices stable for 5 cycles; arr_bias_en never 1; done after wb.
REQ-038 start with cfg_k_tiles=0 -> err pulse 1 cycle later, busy stays 0, no ld_valid.
REQ-039 TIMEOUT=16, arr_done never returned -> err pulse 16 cycles into WAIT, return to IDLE, busy=0.
REQ-040 rst pulled low in WB with wb_ready=0 -> all outputs 0 same cycle; start after release runs a fresh job from k=n=0.
REQ-041 wb_ready low 3 cycles and start toggled mid-job -> wb_valid/wb_n_idx held; start ignored; exactly one done.
